// File: rtl/udp_pkg.sv
// Shared types and constants for the IPv4/UDP payload extractor.
package udp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IP_HDR,
    UDP_HDR,
    PAYLOAD,
    DROP
  } state_t;

  typedef enum logic [2:0] {
    TRUNC    = 3'd0,
    ABORT    = 3'd1,
    BAD_VER  = 3'd2,
    FRAG     = 3'd3,
    NOT_UDP  = 3'd4,
    BAD_CSUM = 3'd5,
    BAD_LEN  = 3'd6,
    PORT     = 3'd7
  } drop_code_t;

  localparam logic [7:0]  IPPROTO_UDP = 8'h11;
  localparam logic [3:0]  IPV4_VER    = 4'h4;
  localparam logic [15:0] UDP_HDR_LEN = 16'd8;

endpackage

// File: rtl/ip_csum_acc.sv
// Byte-serial ones-complement accumulator; even bytes are the high half of a word.
module ip_csum_acc (
  input  logic        main_clk,
  input  logic        main_rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  input  logic        odd,
  output logic [15:0] sum,
  output logic [15:0] sum_next
);

  logic [15:0] base;
  logic [15:0] word;
  logic [16:0] raw;

  // A clear coinciding with an enable starts a new sum from this byte.
  assign base     = clr ? 16'h0000 : sum;
  assign word     = odd ? {8'h00, data} : {data, 8'h00};
  assign raw      = {1'b0, base} + {1'b0, word};
  assign sum_next = raw[15:0] + {15'd0, raw[16]};

  always_ff @(posedge main_clk) begin
    if (main_rst)  sum <= 16'h0000;
    else if (en)   sum <= sum_next;
    else if (clr)  sum <= 16'h0000;
  end

endmodule

// File: rtl/udp_payload_extract.sv
// Parses IPv4 + UDP headers from a byte stream and emits the UDP payload.
module udp_payload_extract
  import udp_pkg::*;
#(
  parameter logic        FILTER_EN = 1'b0,
  parameter logic [15:0] DST_PORT  = 16'd5000
) (
  input  logic        main_clk,
  input  logic        main_rst,
  input  logic [7:0]  ip_byte,
  input  logic        ip_valid,
  input  logic        ip_sof,
  input  logic        ip_eof,
  output logic [15:0] udp_src_port,
  output logic [15:0] udp_dst_port,
  output logic [15:0] udp_len,
  output logic        hdr_valid,
  output logic [7:0]  payload_byte,
  output logic        payload_valid,
  output logic        payload_last,
  output logic        payload_err,
  output logic        pkt_drop,
  output logic [2:0]  drop_code
);

  state_t      state;
  logic [5:0]  hdr_cnt;
  logic [5:0]  hdr_bytes;
  logic [2:0]  udp_cnt;
  logic [15:0] src_sh, dst_sh, len_sh;
  logic [15:0] remaining;

  logic        csum_clr, csum_en, csum_odd;
  logic [15:0] unused_csum_sum;
  logic [15:0] csum_next;

  logic        ver_bad;
  logic        ip_last;
  logic        ip_fail;
  drop_code_t  ip_code;
  logic        udp_fail;
  drop_code_t  udp_code;

  assign csum_clr = ip_valid & ip_sof;
  assign csum_en  = ip_valid & (ip_sof | (state == IP_HDR));
  assign csum_odd = ip_sof ? 1'b0 : hdr_cnt[0];

  ip_csum_acc u_csum (
    .main_clk (main_clk),
    .main_rst (main_rst),
    .clr      (csum_clr),
    .en       (csum_en),
    .data     (ip_byte),
    .odd      (csum_odd),
    .sum      (unused_csum_sum),
    .sum_next (csum_next)
  );

  assign ver_bad = (ip_byte[7:4] != IPV4_VER) || (ip_byte[3:0] < 4'd5);
  assign ip_last = (hdr_cnt == hdr_bytes - 6'd1);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    ip_fail = 1'b0;
    ip_code = TRUNC;
    if (hdr_cnt == 6'd6 && (ip_byte[5] || ip_byte[4:0] != 5'd0)) begin
      ip_fail = 1'b1;
      ip_code = FRAG;
    end else if (hdr_cnt == 6'd7 && ip_byte != 8'h00) begin
      ip_fail = 1'b1;
      ip_code = FRAG;
    end else if (hdr_cnt == 6'd9 && ip_byte != IPPROTO_UDP) begin
      ip_fail = 1'b1;
      ip_code = NOT_UDP;
    end else if (ip_last && csum_next != 16'hFFFF) begin
      ip_fail = 1'b1;
      ip_code = BAD_CSUM;
    end else if (ip_eof) begin
      ip_fail = 1'b1;
      ip_code = TRUNC;
    end
  end

  // Length and port are fully assembled by the time udp_cnt reaches 7.
  always_comb begin
    udp_fail = 1'b0;
    udp_code = TRUNC;
    if (udp_cnt != 3'd7) begin
      udp_fail = ip_eof;
    end else if (len_sh < UDP_HDR_LEN) begin
      udp_fail = 1'b1;
      udp_code = BAD_LEN;
    end else if (FILTER_EN && dst_sh != DST_PORT) begin
      udp_fail = 1'b1;
      udp_code = PORT;
    end else if (ip_eof && len_sh != UDP_HDR_LEN) begin
      udp_fail = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all branches see pre-edge values.
  always_ff @(posedge main_clk) begin
    if (main_rst) begin
      state         <= IDLE;
      hdr_cnt       <= '0;
      hdr_bytes     <= '0;
      udp_cnt       <= '0;
      src_sh        <= '0;
      dst_sh        <= '0;
      len_sh        <= '0;
      remaining     <= '0;
      udp_src_port  <= '0;
      udp_dst_port  <= '0;
      udp_len       <= '0;
      hdr_valid     <= 1'b0;
      payload_byte  <= '0;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      payload_err   <= 1'b0;
      pkt_drop      <= 1'b0;
      drop_code     <= '0;
    end else begin
      hdr_valid     <= 1'b0;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      payload_err   <= 1'b0;
      pkt_drop      <= 1'b0;
      if (ip_valid) begin
        if (ip_sof) begin
          hdr_cnt   <= 6'd1;
          udp_cnt   <= 3'd0;
          hdr_bytes <= {ip_byte[3:0], 2'b00};
          if (ip_eof) begin
            pkt_drop  <= 1'b1;
            drop_code <= TRUNC;
            state     <= IDLE;
          end else if (state == IP_HDR || state == UDP_HDR || state == PAYLOAD) begin
            // The old packet's abort takes the single drop pulse.
            pkt_drop  <= 1'b1;
            drop_code <= ABORT;
            state     <= ver_bad ? DROP : IP_HDR;
          end else if (ver_bad) begin
            pkt_drop  <= 1'b1;
            drop_code <= BAD_VER;
            state     <= DROP;
          end else begin
            state <= IP_HDR;
          end
        end else begin
          case (state)
            IP_HDR: begin
              hdr_cnt <= hdr_cnt + 6'd1;
              if (ip_fail) begin
                pkt_drop  <= 1'b1;
                drop_code <= ip_code;
                state     <= ip_eof ? IDLE : DROP;
              end else if (ip_last) begin
                udp_cnt <= 3'd0;
                state   <= UDP_HDR;
              end
            end
            UDP_HDR: begin
              udp_cnt <= udp_cnt + 3'd1;
              case (udp_cnt)
                3'd0:    src_sh[15:8] <= ip_byte;
                3'd1:    src_sh[7:0]  <= ip_byte;
                3'd2:    dst_sh[15:8] <= ip_byte;
                3'd3:    dst_sh[7:0]  <= ip_byte;
                3'd4:    len_sh[15:8] <= ip_byte;
                3'd5:    len_sh[7:0]  <= ip_byte;
                default: ;
              endcase
              if (udp_fail) begin
                pkt_drop  <= 1'b1;
                drop_code <= udp_code;
                state     <= ip_eof ? IDLE : DROP;
              end else if (udp_cnt == 3'd7) begin
                hdr_valid    <= 1'b1;
                udp_src_port <= src_sh;
                udp_dst_port <= dst_sh;
                udp_len      <= len_sh;
                remaining    <= len_sh - UDP_HDR_LEN;
                state        <= (len_sh == UDP_HDR_LEN) ? IDLE : PAYLOAD;
              end
            end
            PAYLOAD: begin
              payload_valid <= 1'b1;
              payload_byte  <= ip_byte;
              remaining     <= remaining - 16'd1;
              if (remaining == 16'd1) begin
                payload_last <= 1'b1;
                state        <= IDLE;
              end else if (ip_eof) begin
                payload_last <= 1'b1;
                payload_err  <= 1'b1;
                state        <= IDLE;
              end
            end
            DROP: begin
              if (ip_eof) state <= IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_udp_payload_extract.sv
// Scoreboard bench: one unfiltered and one port-filtered instance share the stimulus.
module tb_udp_payload_extract;

  logic        main_clk;
  logic        main_rst;
  logic [7:0]  ip_byte;
  logic        ip_valid, ip_sof, ip_eof;

  logic [15:0] src_port [2];
  logic [15:0] dst_port [2];
  logic [15:0] len_out  [2];
  logic [7:0]  pay_byte [2];
  logic [2:0]  code_out [2];
  logic [1:0]  hdr_valid, pay_valid, pay_last, pay_err, pkt_drop;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    udp_payload_extract #(.FILTER_EN(g == 1), .DST_PORT(16'd5000)) u_dut (
      .main_clk      (main_clk),
      .main_rst      (main_rst),
      .ip_byte       (ip_byte),
      .ip_valid      (ip_valid),
      .ip_sof        (ip_sof),
      .ip_eof        (ip_eof),
      .udp_src_port  (src_port[g]),
      .udp_dst_port  (dst_port[g]),
      .udp_len       (len_out[g]),
      .hdr_valid     (hdr_valid[g]),
      .payload_byte  (pay_byte[g]),
      .payload_valid (pay_valid[g]),
      .payload_last  (pay_last[g]),
      .payload_err   (pay_err[g]),
      .pkt_drop      (pkt_drop[g]),
      .drop_code     (code_out[g])
    );
  end

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ev_hdr(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    return {1'b0, 2'd1, s, d, l, 8'd0, 2'b00, 3'd0};
  endfunction
  function automatic logic [63:0] ev_pay(input logic [7:0] b, input logic last, input logic err);
    return {1'b0, 2'd2, 48'd0, b, last, err, 3'd0};
  endfunction
  function automatic logic [63:0] ev_drop(input logic [2:0] c);
    return {1'b0, 2'd3, 48'd0, 8'd0, 2'b00, c};
  endfunction

  logic [63:0] q0[$];
  logic [63:0] q1[$];

  task automatic push(input logic [1:0] mask, input logic [63:0] ev);
    if (mask[0]) q0.push_back(ev);
    if (mask[1]) q1.push_back(ev);
  endtask

  always @(negedge main_clk) begin
    for (int d = 0; d < 2; d++) begin
      int n;
      logic [63:0] obs, exp;
      n = int'(hdr_valid[d]) + int'(pay_valid[d]) + int'(pkt_drop[d]);
      if (!pay_valid[d]) check($sformatf("qualifier%0d", d), {62'd0, pay_last[d], pay_err[d]}, 64'd0);
      if (n > 1) begin
        check($sformatf("multi_event%0d", d), n, 1);
      end else if (n == 1) begin
        if (hdr_valid[d])      obs = ev_hdr(src_port[d], dst_port[d], len_out[d]);
        else if (pay_valid[d]) obs = ev_pay(pay_byte[d], pay_last[d], pay_err[d]);
        else                   obs = ev_drop(code_out[d]);
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          check($sformatf("unexpected_event%0d", d), obs, 64'd0);
        end else begin
          if (d == 0) exp = q0.pop_front();
          else        exp = q1.pop_front();
          check($sformatf("event%0d", d), obs, exp);
        end
      end
    end
  end

  logic [7:0] pkt[$];
  logic [7:0] pay[$];

  task automatic build(input logic [3:0] ver, input logic [3:0] ihl, input logic [7:0] proto,
                       input logic [15:0] frag, input logic [15:0] sp, input logic [15:0] dp,
                       input logic [15:0] ulen, input int flip);
    logic [7:0]  h[$];
    logic [15:0] tot, cs;
    int          sum;
    tot = 16'(int'(ihl) * 4) + ulen;
    h.push_back({ver, ihl}); h.push_back(8'h00);
    h.push_back(tot[15:8]);  h.push_back(tot[7:0]);
    h.push_back(8'h1c);      h.push_back(8'h46);
    h.push_back(frag[15:8]); h.push_back(frag[7:0]);
    h.push_back(8'h40);      h.push_back(proto);
    h.push_back(8'h00);      h.push_back(8'h00);
    h.push_back(8'hc0); h.push_back(8'ha8); h.push_back(8'h00); h.push_back(8'h01);
    h.push_back(8'hc0); h.push_back(8'ha8); h.push_back(8'h00); h.push_back(8'h02);
    for (int i = 20; i < int'(ihl) * 4; i++) h.push_back(8'h01);
    while (h.size() < 20) h.push_back(8'h00);
    sum = 0;
    for (int i = 0; i + 1 < h.size(); i += 2) sum += int'({h[i], h[i+1]});
    while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
    cs = ~sum[15:0];
    h[10] = cs[15:8];
    h[11] = cs[7:0];
    if (flip >= 0) h[flip] = h[flip] ^ 8'h04;
    pkt = h;
    pkt.push_back(sp[15:8]);   pkt.push_back(sp[7:0]);
    pkt.push_back(dp[15:8]);   pkt.push_back(dp[7:0]);
    pkt.push_back(ulen[15:8]); pkt.push_back(ulen[7:0]);
    pkt.push_back(8'h00);      pkt.push_back(8'h00);
    foreach (pay[i]) pkt.push_back(pay[i]);
  endtask

  task automatic load_dead();
    pay.delete();
    pay.push_back(8'hDE); pay.push_back(8'hAD); pay.push_back(8'hBE); pay.push_back(8'hEF);
  endtask

  task automatic load_seq(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'(8'h30 + i * 7));
  endtask

  task automatic gap();
    ip_valid = 1'b0;
    ip_byte  = 8'($urandom);
    ip_sof   = 1'b1;
    ip_eof   = 1'b1;
    @(posedge main_clk); #1;
    ip_sof = 1'b0;
    ip_eof = 1'b0;
  endtask

  task automatic send_n(input int n, input bit eof);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) gap();
      ip_valid = 1'b1;
      ip_byte  = pkt[i];
      ip_sof   = (i == 0);
      ip_eof   = eof && (i == n - 1);
      @(posedge main_clk); #1;
      ip_valid = 1'b0;
      ip_sof   = 1'b0;
      ip_eof   = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge main_clk); #1; end
  endtask

  task automatic exp_good(input logic [1:0] mask, input logic [15:0] sp, input logic [15:0] dp,
                          input logic [15:0] ulen, input int n_pay, input bit trunc);
    push(mask, ev_hdr(sp, dp, ulen));
    for (int i = 0; i < n_pay; i++)
      push(mask, ev_pay(pay[i], i == n_pay - 1, trunc && (i == n_pay - 1)));
  endtask

  function automatic logic [63:0] out_vec(input int d);
    return {src_port[d], dst_port[d], len_out[d], pay_byte[d],
            hdr_valid[d], pay_valid[d], pay_last[d], pay_err[d], pkt_drop[d], code_out[d]};
  endfunction

  initial begin
    main_rst = 1'b1;
    ip_valid = 1'b0; ip_sof = 1'b0; ip_eof = 1'b0; ip_byte = 8'h00;
    repeat (3) @(posedge main_clk);
    @(negedge main_clk);
    check("reset_out0", out_vec(0), 64'd0);
    check("reset_out1", out_vec(1), 64'd0);
    @(posedge main_clk); #1;
    main_rst = 1'b0;
    idle(2);

    // Minimal datagram followed by 18 bytes of Ethernet padding.
    load_dead();
    build(4'h4, 4'd5, 8'h11, 16'h4000, 16'h1234, 16'h1388, 16'd12, -1);
    repeat (18) pkt.push_back(8'h00);
    exp_good(2'b11, 16'h1234, 16'h1388, 16'd12, 4, 1'b0);
    send_n(pkt.size(), 1'b1); idle(4);

    // One flipped header bit.
    build(4'h4, 4'd5, 8'h11, 16'h4000, 16'h1234, 16'h1388, 16'd12, 12);
    push(2'b11, ev_drop(3'd5));
    send_n(pkt.size(), 1'b1); idle(4);

    // IHL=6 with options, then a TCP header.
    load_seq(3);
    build(4'h4, 4'd6, 8'h11, 16'h4000, 16'hABCD, 16'h1388, 16'd11, -1);
    exp_good(2'b11, 16'hABCD, 16'h1388, 16'd11, 3, 1'b0);
    send_n(pkt.size(), 1'b1); idle(4);
    build(4'h4, 4'd5, 8'h06, 16'h4000, 16'hABCD, 16'h1388, 16'd11, -1);
    push(2'b11, ev_drop(3'd4));
    send_n(pkt.size(), 1'b1); idle(4);

    // Port filter: only the filtered instance rejects port 80.
    load_dead();
    build(4'h4, 4'd5, 8'h11, 16'h4000, 16'h0400, 16'd80, 16'd12, -1);
    exp_good(2'b01, 16'h0400, 16'd80, 16'd12, 4, 1'b0);
    push(2'b10, ev_drop(3'd7));
    send_n(pkt.size(), 1'b1); idle(4);

    // Zero-length payload, then an undersized length field.
    pay.delete();
    build(4'h4, 4'd5, 8'h11, 16'h4000, 16'h0777, 16'h1388, 16'd8, -1);
    repeat (6) pkt.push_back(8'h55);
    push(2'b11, ev_hdr(16'h0777, 16'h1388, 16'd8));
    send_n(pkt.size(), 1'b1); idle(4);
    build(4'h4, 4'd5, 8'h11, 16'h4000, 16'h0777, 16'h1388, 16'd4, -1);
    push(2'b11, ev_drop(3'd6));
    send_n(pkt.size(), 1'b1); idle(4);

    // Frame ends on the 5th of 12 payload bytes.
    load_seq(12);
    build(4'h4, 4'd5, 8'h11, 16'h4000, 16'h2222, 16'h1388, 16'd20, -1);
    exp_good(2'b11, 16'h2222, 16'h1388, 16'd20, 5, 1'b1);
    send_n(28 + 5, 1'b1); idle(4);

    // Header rejects: version, IHL, MF, fragment offset.
    build(4'h6, 4'd5, 8'h11, 16'h4000, 16'h1, 16'h1388, 16'd20, -1);
    push(2'b11, ev_drop(3'd2));
    send_n(pkt.size(), 1'b1); idle(3);
    build(4'h4, 4'd4, 8'h11, 16'h4000, 16'h1, 16'h1388, 16'd20, -1);
    push(2'b11, ev_drop(3'd2));
    send_n(pkt.size(), 1'b1); idle(3);
    build(4'h4, 4'd5, 8'h11, 16'h2000, 16'h1, 16'h1388, 16'd20, -1);
    push(2'b11, ev_drop(3'd3));
    send_n(pkt.size(), 1'b1); idle(3);
    build(4'h4, 4'd5, 8'h11, 16'h0001, 16'h1, 16'h1388, 16'd20, -1);
    push(2'b11, ev_drop(3'd3));
    send_n(pkt.size(), 1'b1); idle(3);

    // Truncation inside the IP header, inside the UDP header, and sof+eof together.
    build(4'h4, 4'd5, 8'h11, 16'h4000, 16'h1, 16'h1388, 16'd20, -1);
    push(2'b11, ev_drop(3'd0));
    send_n(10, 1'b1); idle(3);
    push(2'b11, ev_drop(3'd0));
    send_n(24, 1'b1); idle(3);
    push(2'b11, ev_drop(3'd0));
    send_n(1, 1'b1); idle(3);

    // New frame starts mid-payload.
    build(4'h4, 4'd5, 8'h11, 16'h4000, 16'h3333, 16'h1388, 16'd20, -1);
    push(2'b11, ev_hdr(16'h3333, 16'h1388, 16'd20));
    for (int i = 0; i < 3; i++) push(2'b11, ev_pay(pay[i], 1'b0, 1'b0));
    send_n(31, 1'b0);
    push(2'b11, ev_drop(3'd1));
    load_dead();
    build(4'h4, 4'd5, 8'h11, 16'h4000, 16'h1234, 16'h1388, 16'd12, -1);
    exp_good(2'b11, 16'h1234, 16'h1388, 16'd12, 4, 1'b0);
    send_n(pkt.size(), 1'b1); idle(4);

    // Reset in the middle of the payload.
    load_seq(6);
    build(4'h4, 4'd5, 8'h11, 16'h4000, 16'h4444, 16'h1388, 16'd14, -1);
    push(2'b11, ev_hdr(16'h4444, 16'h1388, 16'd14));
    for (int i = 0; i < 3; i++) push(2'b11, ev_pay(pay[i], 1'b0, 1'b0));
    send_n(31, 1'b0);
    main_rst = 1'b1;
    @(posedge main_clk);
    @(negedge main_clk);
    check("midrst_out0", out_vec(0), 64'd0);
    check("midrst_out1", out_vec(1), 64'd0);
    @(posedge main_clk); #1;
    main_rst = 1'b0;
    idle(2);
    load_dead();
    build(4'h4, 4'd5, 8'h11, 16'h4000, 16'h5555, 16'h1388, 16'd12, -1);
    exp_good(2'b11, 16'h5555, 16'h1388, 16'd12, 4, 1'b0);
    send_n(pkt.size(), 1'b1); idle(6);

    check("pending0", q0.size(), 0);
    check("pending1", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_payload_extract.md
Name: udp_payload_extract

Overview:
- Consumes the byte stream that follows the Ethernet header: IPv4 header, then UDP header, then payload. Its sideband marks the first IPv4 byte and the last frame byte.
- Validates the IPv4 header, including the header checksum, and requires protocol UDP.
- Extracts the UDP source port, destination port and length, and emits the UDP payload as a byte stream with last/error flags.
- Sits directly downstream of the Ethernet/preamble parser (udp_main); its output feeds application logic.

Parameters:
- FILTER_EN, 1'b0, when 1, drop datagrams whose destination port differs from DST_PORT.
- DST_PORT, 16'd5000, destination port accepted when FILTER_EN=1.

Ports:
- main_clk  in  1  single clock domain.
- main_rst  in  1  synchronous, active-high reset.
- ip_byte  in  8  input data byte.
- ip_valid  in  1  ip_byte is valid this cycle; no backpressure.
- ip_sof  in  1  qualified by ip_valid; marks byte 0 of the IPv4 header.
- ip_eof  in  1  qualified by ip_valid; marks the last byte of the frame.
- udp_src_port  out  16  registered; held until the next hdr_valid.
- udp_dst_port  out  16  registered; held until the next hdr_valid.
- udp_len  out  16  UDP length field; held until the next hdr_valid.
- hdr_valid  out  1  one-cycle pulse: UDP header accepted.
- payload_byte  out  8  payload data.
- payload_valid  out  1  payload_byte is valid.
- payload_last  out  1  final payload byte, qualified by payload_valid.
- payload_err  out  1  with payload_last: datagram was truncated.
- pkt_drop  out  1  one-cycle pulse: packet rejected or aborted.
- drop_code  out  3  reason for the drop; valid with pkt_drop.

Behaviour:
- Reset: all outputs 0; state IDLE; counters and checksum accumulator cleared. Reset mid-packet discards the packet without a pkt_drop pulse.
- Only ip_valid cycles advance the block. All outputs are registered, giving 1 cycle of latency from the input byte.
- States: IDLE, IP_HDR, UDP_HDR, PAYLOAD, DROP.
- ip_sof with ip_valid in any state loads byte 0 and enters IP_HDR.
  - If this interrupts IP_HDR, UDP_HDR or PAYLOAD, pulse pkt_drop with drop_code=ABORT.
  - If the interrupted state is PAYLOAD, no payload_last is issued.
- IP_HDR checks, with hdr_cnt in the range 0..59:
  - Byte 0: version must be 4, else drop with BAD_VER. IHL must be at least 5, else drop with BAD_VER. Latch hdr_bytes = IHL*4.
  - Bytes 6-7: MF=1 or nonzero fragment offset → drop with FRAG.
  - Byte 9: protocol must be 8'h11, else drop with NOT_UDP.
  - Options bytes (hdr_cnt 20 .. hdr_bytes-1) are consumed and checksummed only.
- Checksum:
  - Ones-complement sum of 16-bit words; even hdr_cnt supplies the high byte, odd hdr_cnt the low byte.
  - 17-bit accumulator with end-around carry folded on every add.
  - On the byte at hdr_cnt == hdr_bytes-1, the folded sum including that byte must equal 16'hFFFF, else drop with BAD_CSUM. On pass, enter UDP_HDR.
- UDP_HDR, 8 bytes, big-endian: src port, dst port, length, checksum. The UDP checksum is ignored.
  - After byte 7: if udp_len < 8 → drop with BAD_LEN.
  - Else if FILTER_EN=1 and dst port ≠ DST_PORT → drop with PORT.
  - Else pulse hdr_valid and update the port/length outputs in the same cycle.
  - If udp_len == 8, return to IDLE with no payload. Otherwise load remaining = udp_len-8 (16-bit) and enter PAYLOAD.
- PAYLOAD: each byte is output and remaining is decremented.
  - When remaining == 1: payload_last=1, then go to IDLE.
  - Trailing bytes (Ethernet padding, FCS) are ignored in IDLE.
- ip_eof before the datagram or header completes:
  - In PAYLOAD: output that byte with payload_last=1 and payload_err=1, then go to IDLE.
  - In IP_HDR or UDP_HDR: drop with TRUNC.
- DROP: a drop pulses pkt_drop for 1 cycle. The block then ignores bytes until ip_sof, or goes to IDLE on ip_eof.
- If ip_eof coincides with the drop-causing byte, go directly to IDLE.
- ip_sof and ip_eof asserted on the same byte: treat as TRUNC.

Decomposition:
- Package udp_pkg holds:
  - state_t.
  - drop_code_t: ABORT=1, BAD_VER=2, FRAG=3, NOT_UDP=4, BAD_CSUM=5, BAD_LEN=6, PORT=7, TRUNC=0.
  - Constants IPPROTO_UDP=8'h11, IPV4_VER=4'h4, UDP_HDR_LEN=8.
- Sub-module ip_csum_acc: byte-serial ones-complement accumulator. Inputs are clr, en, byte, odd. Outputs are sum[15:0] and the combinational next-sum.

Test Plan:
- Minimal valid datagram: IHL=5, proto 0x11, correct checksum, ports 0x1234→0x1388, udp_len=12, payload DE AD BE EF. Expect hdr_valid ×1, 4 payload bytes with payload_last on 0xEF, no pkt_drop.
- Header checksum corrupted by flipping 1 bit → pkt_drop with drop_code=BAD_CSUM; no hdr_valid, no payload.
- IHL=6 with 4 options bytes and a valid checksum → payload correctly aligned. Then proto=0x06 → NOT_UDP.
- FILTER_EN=1, DST_PORT=5000, datagram with dst port 80 → drop with PORT. Then udp_len=8 → hdr_valid and zero payload bytes.
- udp_len=20, but ip_eof arrives on the 5th payload byte → payload_last=1 with payload_err=1 on that byte. Then 18 bytes of padding after a good packet → ignored.
- ip_sof asserted mid-payload → pkt_drop with ABORT, new packet parsed correctly. main_rst mid-packet → all outputs 0 the next cycle.
